axi_lite_buffer: RTL
====================

// Module: axi_lite_buffer
// PURPOSE
//  Parametrised AXI-Lite buffer between an upstream master and a downstream slave.
//  Each of the five channels (AW, W, B, AR, R) gets an independently sized FIFO.
//  Optional per-direction outstanding-transaction limit.
//  Used for timing closure and decoupling on bus crossings, e.g. in front of
//  interconnects and slow peripherals.
// PARAMETERS
//  ADDR_WIDTH      32  address width, both interfaces
//  DATA_WIDTH      32  data width; checked exactly as axi_lite_channel checks it
//  RELAX_CHECK     0   passed to axi_lite_channel width check
//  AW_DEPTH        2   AW FIFO entries; 0 = combinational passthrough
//  W_DEPTH         2   W FIFO entries; 0 = passthrough
//  B_DEPTH         2   B FIFO entries; 0 = passthrough
//  AR_DEPTH        2   AR FIFO entries; 0 = passthrough
//  R_DEPTH         2   R FIFO entries; 0 = passthrough
//  MAX_OUTSTANDING 0   max in-flight writes and max in-flight reads, counted separately; 0 = unlimited
// PORTS
//  clk             input   1                         clock; all state on rising edge
//  rst             input   1                         synchronous, active-high reset
//  host            modport axi_lite_channel.slave    upstream side; its clk/rstn are unused
//  device          modport axi_lite_channel.master   downstream side; its clk/rstn are unused
//  wr_outstanding  output  $clog2(MAX_OUTSTANDING+1) in-flight writes (width 1, tied 0, if limit is 0)
//  rd_outstanding  output  $clog2(MAX_OUTSTANDING+1) in-flight reads (same width rule)
// BEHAVIOUR
//  FIFO payloads (fields unmodified):
//   - AW/AR use ax_pack_t; W uses w_pack_t; B carries resp; R uses r_pack_t.
//   - Forward channels flow host->device; B and R flow device->host.
//  FIFO with DEPTH >= 1:
//   - in_ready = !full, taken from a register; it never depends on same-cycle out_ready.
//   - out_valid = !empty, taken from a register.
//   - Push on in_valid&&in_ready; pop on out_valid&&out_ready.
//   - Push and pop in the same cycle leave occupancy unchanged.
//   - Latency: a beat pushed in cycle N is visible at the output in cycle N+1. No fall-through.
//   - DEPTH=1 sustains 1 beat per 2 cycles. DEPTH>=2 sustains 1 beat per cycle.
//   - Read/write pointers wrap modulo DEPTH; DEPTH need not be a power of 2.
//   - Full: in_ready=0 even if a pop happens that cycle; in_ready rises the next cycle.
//   - Empty: out_valid=0; output payload is don't-care.
//  DEPTH = 0:
//   - Wires only: valid, ready and payload pass straight through. Zero latency, no state.
//  Outstanding limit (MAX_OUTSTANDING > 0):
//   - wr_cnt increments on host AW handshake and decrements on host B handshake.
//   - rd_cnt does the same for AR and R.
//   - Increment and decrement in the same cycle: count unchanged.
//   - host.aw_ready = AW FIFO ready && wr_cnt < MAX_OUTSTANDING; host.ar_ready uses rd_cnt likewise.
//   - Counters never exceed MAX_OUTSTANDING and never underflow.
//   - A B or R beat arriving with count 0 is a protocol error: simulation assertion fires, count stays 0.
//   - W is not gated by the limit.
//  Reset (rst=1 on a clock edge):
//   - All FIFOs empty; counters 0; all host ready and device valid outputs 0 while rst is high.
//   - Readies rise on the first cycle after rst falls. Payload outputs are don't-care.
//   - Reset mid-transfer discards all buffered beats without emitting them; no partial beat reaches either side.
//   - DEPTH=0 channels are not masked by reset (pure wires).
// TESTING
//  1. All DEPTH=2, device always ready; 8 back-to-back AW+W writes, addr 0x0,0x4..0x1C
//     -> device sees 8 beats on consecutive cycles, first 1 cycle after host handshake; order preserved.
//  2. AW_DEPTH=4, device.aw_ready=0; host pushes 6 AWs
//     -> host.aw_ready drops after the 4th; release ready -> all 6 arrive in order, none lost.
//  3. MAX_OUTSTANDING=2; 3 reads issued, R held off
//     -> host.ar_ready=0 after 2 handshakes, rd_outstanding=2; one R returned -> 3rd AR accepted next cycle.
//  4. Same-cycle AR handshake and R handshake at rd_cnt=1 -> rd_outstanding stays 1.
//  5. R_DEPTH=0, AR_DEPTH=1: AR passes with 1-cycle latency at half rate; R data 0xDEADBEEF appears same cycle.
//  6. rst pulse with 3 beats buffered in W FIFO
//     -> device.w_valid=0 during reset and after it; host.w_ready=1 one cycle after rst falls; counters read 0.

Source files
------------

// File: rtl/axi_lite_buffer_if.sv
// rtl/axi_lite_buffer_if.sv - AXI-Lite channel bundle shared by both sides of the buffer
interface axi_lite_channel #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter bit RELAX_CHECK = 1'b0
) (
  input logic clk,
  input logic rstn
);
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    b_valid;
  logic                    b_ready;
  logic [1:0]              b_resp;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;
  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;

  // Strict mode admits only the two standard AXI-Lite widths; relaxed mode any whole-byte width
  if (RELAX_CHECK ? (DATA_WIDTH % 8 != 0) : (DATA_WIDTH != 32 && DATA_WIDTH != 64)) begin : g_bad_width
    $error("axi_lite_channel: unsupported DATA_WIDTH %0d", DATA_WIDTH);
  end

  modport master (
    input  clk, rstn,
    output aw_valid, aw_addr, aw_prot, input aw_ready,
    output w_valid, w_data, w_strb, input w_ready,
    input  b_valid, b_resp, output b_ready,
    output ar_valid, ar_addr, ar_prot, input ar_ready,
    input  r_valid, r_data, r_resp, output r_ready
  );

  modport slave (
    input  clk, rstn,
    input  aw_valid, aw_addr, aw_prot, output aw_ready,
    input  w_valid, w_data, w_strb, output w_ready,
    output b_valid, b_resp, input b_ready,
    input  ar_valid, ar_addr, ar_prot, output ar_ready,
    output r_valid, r_data, r_resp, input r_ready
  );
endinterface

// File: rtl/axi_lite_buffer.sv
// rtl/axi_lite_buffer.sv - per-channel AXI-Lite FIFOs with optional outstanding-transaction limit
module axi_lite_buffer_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk | rst;
    assign out_valid      = in_valid;
    assign in_ready       = out_ready;
    assign out_data       = in_data;
  end else begin : g_fifo
    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_next;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 push;
    logic                 pop;

    // Both flags are registered so neither side sees a combinational path through the FIFO
    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid_q && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = mem[rd_ptr];

    always_comb begin
      count_next = count;
      if (push && !pop) begin
        count_next = count + 1'b1;
      end else if (pop && !push) begin
        count_next = count - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        in_ready_q  <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        count       <= count_next;
        in_ready_q  <= (count_next != FULL_CNT);
        out_valid_q <= (count_next != '0);
        if (push) begin
          wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr] <= in_data;
      end
    end
  end
endmodule

module axi_lite_buffer #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter bit RELAX_CHECK     = 1'b0,
  parameter int AW_DEPTH        = 2,
  parameter int W_DEPTH         = 2,
  parameter int B_DEPTH         = 2,
  parameter int AR_DEPTH        = 2,
  parameter int R_DEPTH         = 2,
  parameter int MAX_OUTSTANDING = 0,
  localparam int CNT_WIDTH      = (MAX_OUTSTANDING > 0) ? $clog2(MAX_OUTSTANDING + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_lite_channel.slave       host,
  axi_lite_channel.master      device,
  output logic [CNT_WIDTH-1:0] wr_outstanding,
  output logic [CNT_WIDTH-1:0] rd_outstanding
);
  if (RELAX_CHECK ? (DATA_WIDTH % 8 != 0) : (DATA_WIDTH != 32 && DATA_WIDTH != 64)) begin : g_bad_width
    $error("axi_lite_buffer: unsupported DATA_WIDTH %0d", DATA_WIDTH);
  end

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            prot;
  } ax_pack_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
  } w_pack_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
  } r_pack_t;

  ax_pack_t aw_in, aw_out, ar_in, ar_out;
  w_pack_t  w_in, w_out;
  r_pack_t  r_in, r_out;
  logic     aw_fifo_ready, ar_fifo_ready;
  logic     wr_ok, rd_ok;
  logic     unused_sideband;

  assign unused_sideband = host.clk ^ host.rstn ^ device.clk ^ device.rstn;

  assign aw_in = '{addr: host.aw_addr, prot: host.aw_prot};
  assign ar_in = '{addr: host.ar_addr, prot: host.ar_prot};
  assign w_in  = '{data: host.w_data, strb: host.w_strb};
  assign r_in  = '{data: device.r_data, resp: device.r_resp};

  assign device.aw_addr = aw_out.addr;
  assign device.aw_prot = aw_out.prot;
  assign device.ar_addr = ar_out.addr;
  assign device.ar_prot = ar_out.prot;
  assign device.w_data  = w_out.data;
  assign device.w_strb  = w_out.strb;
  assign host.r_data    = r_out.data;
  assign host.r_resp    = r_out.resp;

  // The limit gates the FIFO push as well as host ready so a blocked address never enters
  assign host.aw_ready = aw_fifo_ready && wr_ok;
  assign host.ar_ready = ar_fifo_ready && rd_ok;

  axi_lite_buffer_fifo #(.WIDTH($bits(ax_pack_t)), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk(clk), .rst(rst),
    .in_valid(host.aw_valid && wr_ok), .in_ready(aw_fifo_ready), .in_data(aw_in),
    .out_valid(device.aw_valid), .out_ready(device.aw_ready), .out_data(aw_out)
  );

  axi_lite_buffer_fifo #(.WIDTH($bits(w_pack_t)), .DEPTH(W_DEPTH)) u_w_fifo (
    .clk(clk), .rst(rst),
    .in_valid(host.w_valid), .in_ready(host.w_ready), .in_data(w_in),
    .out_valid(device.w_valid), .out_ready(device.w_ready), .out_data(w_out)
  );

  axi_lite_buffer_fifo #(.WIDTH(2), .DEPTH(B_DEPTH)) u_b_fifo (
    .clk(clk), .rst(rst),
    .in_valid(device.b_valid), .in_ready(device.b_ready), .in_data(device.b_resp),
    .out_valid(host.b_valid), .out_ready(host.b_ready), .out_data(host.b_resp)
  );

  axi_lite_buffer_fifo #(.WIDTH($bits(ax_pack_t)), .DEPTH(AR_DEPTH)) u_ar_fifo (
    .clk(clk), .rst(rst),
    .in_valid(host.ar_valid && rd_ok), .in_ready(ar_fifo_ready), .in_data(ar_in),
    .out_valid(device.ar_valid), .out_ready(device.ar_ready), .out_data(ar_out)
  );

  axi_lite_buffer_fifo #(.WIDTH($bits(r_pack_t)), .DEPTH(R_DEPTH)) u_r_fifo (
    .clk(clk), .rst(rst),
    .in_valid(device.r_valid), .in_ready(device.r_ready), .in_data(r_in),
    .out_valid(host.r_valid), .out_ready(host.r_ready), .out_data(r_out)
  );

  if (MAX_OUTSTANDING > 0) begin : g_limit
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(MAX_OUTSTANDING);
    logic [CNT_WIDTH-1:0] wr_cnt, rd_cnt;
    logic                 aw_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = host.aw_valid && host.aw_ready;
    assign b_hs  = host.b_valid && host.b_ready;
    assign ar_hs = host.ar_valid && host.ar_ready;
    assign r_hs  = host.r_valid && host.r_ready;
    assign wr_ok = (wr_cnt < LIMIT);
    assign rd_ok = (rd_cnt < LIMIT);
    assign wr_outstanding = wr_cnt;
    assign rd_outstanding = rd_cnt;

    // A response at count zero is dropped from the count rather than wrapping it
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_cnt <= '0;
        rd_cnt <= '0;
      end else begin
        wr_cnt <= wr_cnt + CNT_WIDTH'(aw_hs) - CNT_WIDTH'(b_hs && (wr_cnt != '0));
        rd_cnt <= rd_cnt + CNT_WIDTH'(ar_hs) - CNT_WIDTH'(r_hs && (rd_cnt != '0));
      end
    end

    wr_underflow: assert property (@(posedge clk) disable iff (rst) !(b_hs && wr_cnt == '0));
    rd_underflow: assert property (@(posedge clk) disable iff (rst) !(r_hs && rd_cnt == '0));
  end else begin : g_no_limit
    assign wr_ok          = 1'b1;
    assign rd_ok          = 1'b1;
    assign wr_outstanding = '0;
    assign rd_outstanding = '0;
  end
endmodule
